// File: rtl/mux8_rr_arbiter_pkg.sv
// mux8_rr_arbiter_pkg: shared FSM encodings and requester count (rev 1.0)
`default_nettype none

package mux8_rr_arbiter_pkg;

   localparam int unsigned N_REQ = 8;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   function automatic logic [N_REQ-1:0] onehot8(input logic [2:0] idx);
      onehot8 = '0;
      onehot8[idx] = 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mux8_rr_arbiter_mux.sv
// mux_1x8: WIDTH-bit 8:1 data multiplexer (rev 1.0)
`default_nettype none

module mux_1x8 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   input  logic [WIDTH-1:0] in5,
   input  logic [WIDTH-1:0] in6,
   input  logic [WIDTH-1:0] in7,
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] out
);

   always_comb begin
      out = in0;
      case (sel)
         3'd0: out = in0;
         3'd1: out = in1;
         3'd2: out = in2;
         3'd3: out = in3;
         3'd4: out = in4;
         3'd5: out = in5;
         3'd6: out = in6;
         3'd7: out = in7;
         default: out = in0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mux8_rr_arbiter_pick.sv
// rr_pick8: first set request at or after ptr, wrapping 7->0 (rev 1.0)
`default_nettype none

module rr_pick8
   import mux8_rr_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       ptr,
   output logic [2:0]       idx,
   output logic             any
);

   logic [2:0] cand;

   // Scan farthest offset first so the nearest hit to ptr wins.
   always_comb begin
      idx  = ptr;
      cand = ptr;
      for (int k = 7; k >= 0; k--) begin
         cand = ptr + k[2:0];
         if (req[cand]) begin
            idx = cand;
         end
      end
   end

   assign any = |req;

endmodule

`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin 8-input packet arbiter with beat limit (rev 1.0)
`default_nettype none

module mux8_rr_arbiter
   import mux8_rr_arbiter_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       req,
   input  logic [7:0]       last,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   input  logic [WIDTH-1:0] in5,
   input  logic [WIDTH-1:0] in6,
   input  logic [WIDTH-1:0] in7,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic [2:0]       sel,
   output logic [7:0]       grant
);

   localparam logic [7:0] MAX_B = MAX_BEATS[7:0];

   logic [0:0] state_q, state_d;
   logic [2:0] ptr_q,   ptr_d;
   logic [2:0] sel_q,   sel_d;
   logic [7:0] grant_q, grant_d;
   logic [7:0] beats_q, beats_d;

   logic [2:0] pick_idx;
   logic       pick_any;
   logic       xfer;
   logic       rel;
   logic [7:0] beats_inc;

   rr_pick8 u_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   mux_1x8 #(.WIDTH(WIDTH)) u_mux (
      .in0 (in0),
      .in1 (in1),
      .in2 (in2),
      .in3 (in3),
      .in4 (in4),
      .in5 (in5),
      .in6 (in6),
      .in7 (in7),
      .sel (sel_q),
      .out (out)
   );

   assign out_valid = (state_q == BUSY) && req[sel_q];
   assign xfer      = out_valid && out_ready;
   assign beats_inc = beats_q + 8'd1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      beats_d = beats_q;
      rel     = 1'b0;
      if (state_q == IDLE) begin
         if (pick_any) begin
            state_d = BUSY;
            sel_d   = pick_idx;
            grant_d = onehot8(pick_idx);
            beats_d = 8'd0;
         end
      end else begin
         // A vanished request ends the grant even while the sink stalls.
         if (!req[sel_q]) begin
            rel = 1'b1;
         end else if (xfer) begin
            beats_d = beats_inc;
            if (last[sel_q] || (beats_inc == MAX_B)) begin
               rel = 1'b1;
            end
         end
         if (rel) begin
            state_d = IDLE;
            grant_d = 8'd0;
            ptr_d   = sel_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         sel_q   <= 3'd0;
         grant_q <= 8'd0;
         beats_q <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         beats_q <= beats_d;
      end
   end

   assign sel   = sel_q;
   assign grant = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed vector table plus multi-cycle corner sequences (rev 1.0)
`default_nettype none

module tb_mux8_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] last;
   logic       out_ready;
   logic [7:0] din [8];
   logic [7:0] out;
   logic       out_valid;
   logic [2:0] sel;
   logic [7:0] grant;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mux8_rr_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .last      (last),
      .in0       (din[0]),
      .in1       (din[1]),
      .in2       (din[2]),
      .in3       (din[3]),
      .in4       (din[4]),
      .in5       (din[5]),
      .in6       (din[6]),
      .in7       (din[7]),
      .out_ready (out_ready),
      .out       (out),
      .out_valid (out_valid),
      .sel       (sel),
      .grant     (grant)
   );

   typedef struct {
      logic       rst_n;
      logic [7:0] req;
      logic [7:0] last;
      logic       rdy;
      logic [7:0] exp_grant;
      logic [2:0] exp_sel;
      logic       exp_valid;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [7:0] q, input logic [7:0] l,
                               input logic rd, input logic [7:0] g, input logic [2:0] s,
                               input logic v);
      vec_t t;
      t.rst_n = r; t.req = q; t.last = l; t.rdy = rd;
      t.exp_grant = g; t.exp_sel = s; t.exp_valid = v;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] one;
      int         n;
      bit         released;
      one = 8'h01;
      for (int i = 0; i < 8; i++) din[i] = 8'(8'h11 * (i + 1));
      rst_n = 1'b0; req = 8'h00; last = 8'h00; out_ready = 1'b0;

      // Two-requester handoff, then a full round-robin sweep with last on every beat.
      vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h24, 8'h00, 1'b1, 8'h04, 3'd2, 1'b1));
      vecs.push_back(mk(1'b1, 8'h24, 8'h04, 1'b1, 8'h00, 3'd2, 1'b0));
      vecs.push_back(mk(1'b1, 8'h24, 8'h00, 1'b1, 8'h20, 3'd5, 1'b1));
      vecs.push_back(mk(1'b1, 8'h24, 8'h20, 1'b1, 8'h00, 3'd5, 1'b0));
      vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0));
      for (int i = 0; i < 9; i++) begin
         vecs.push_back(mk(1'b1, 8'hFF, 8'hFF, 1'b1, one << (i % 8), 3'(i % 8), 1'b1));
         vecs.push_back(mk(1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00,          3'(i % 8), 1'b0));
      end

      for (int v = 0; v < vecs.size(); v++) begin
         rst_n = vecs[v].rst_n; req = vecs[v].req;
         last = vecs[v].last;   out_ready = vecs[v].rdy;
         tick();
         chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
         chk($sformatf("vec%0d_sel", v), 32'(sel), 32'(vecs[v].exp_sel));
         chk($sformatf("vec%0d_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
         chk($sformatf("vec%0d_out", v), 32'(out), 32'(din[vecs[v].exp_sel]));
      end

      // Beat limit: MAX_BEATS=4 forces release after four transfers.
      rst_n = 1'b0; req = 8'h00; last = 8'h00; out_ready = 1'b0;
      tick();
      rst_n = 1'b1; req = 8'h01; out_ready = 1'b1;
      tick();
      chk("maxb_grant", 32'(grant), 32'h01);
      n = 0;
      released = 1'b0;
      for (int c = 0; c < 10 && !released; c++) begin
         if (out_valid && out_ready) n++;
         tick();
         if (grant == 8'h00) released = 1'b1;
      end
      chk("maxb_released", 32'(released), 32'h1);
      chk("maxb_xfers", 32'(n), 32'd4);
      tick();
      chk("maxb_regrant", 32'(grant), 32'h01);
      chk("maxb_regrant_sel", 32'(sel), 32'd0);

      // Stall: requester 3 granted, sink not ready for five cycles.
      rst_n = 1'b0; req = 8'h00; out_ready = 1'b0;
      tick();
      rst_n = 1'b1; req = 8'h08;
      tick();
      chk("stall_grant", 32'(grant), 32'h08);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'h1);
         chk($sformatf("stall%0d_sel", c), 32'(sel), 32'd3);
         chk($sformatf("stall%0d_beats", c), 32'(dut.beats_q), 32'd0);
      end

      // Request withdrawn mid-grant.
      req = 8'h00;
      #1;
      chk("drop_valid_now", 32'(out_valid), 32'h0);
      tick();
      chk("drop_grant", 32'(grant), 32'h00);

      // Reset during a grant to requester 6.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; req = 8'h40; out_ready = 1'b1;
      tick();
      chk("rst6_grant", 32'(grant), 32'h40);
      chk("rst6_sel", 32'(sel), 32'd6);
      rst_n = 1'b0; req = 8'h41;
      tick();
      chk("rst_mid_grant", 32'(grant), 32'h00);
      chk("rst_mid_sel", 32'(sel), 32'd0);
      chk("rst_mid_valid", 32'(out_valid), 32'h0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_grant", 32'(grant), 32'h01);
      chk("post_rst_sel", 32'(sel), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
